// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the batch sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } sort_state_t;

  // One extra bit so a count can reach DEPTH without wrapping.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/comparator_lt.sv
// Signed less-than comparator; the only magnitude compare in the sorter.
module comparator_lt #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/sort_sequencer.sv
// Batch sorter: load DEPTH signed words, bubble-sort them with one shared
// comparator (one compare-and-swap per clock), then stream them out ascending.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = idx_width(DEPTH);
  localparam logic [IW-1:0] LastCnt  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LastPass = IW'(DEPTH - 2);

  sort_state_t state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] pass_q, pass_d;
  logic          swapped_q, swapped_d;

  logic signed [N-1:0] mem [DEPTH];

  logic [AW-1:0] idx_lo, idx_hi;
  logic [IW-1:0] last_idx;
  logic          lt;
  logic          load_we;
  logic          swap_en;

  assign idx_lo   = idx_q[AW-1:0];
  assign idx_hi   = idx_lo + AW'(1);
  assign last_idx = LastPass - pass_q;

  // a = upper neighbour, b = lower; swap only on strict less-than keeps it stable.
  comparator_lt #(
    .N(N)
  ) u_cmp (
    .a  (mem[idx_hi]),
    .b  (mem[idx_lo]),
    .lt (lt)
  );

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    load_we   = 1'b0;
    swap_en   = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          load_we  = 1'b1;
          wr_idx_d = wr_idx_q + IW'(1);
          if (wr_idx_q == LastCnt) begin
            state_d   = S_SORT;
            wr_idx_d  = '0;
            idx_d     = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end
        end
      end
      S_SORT: begin
        swap_en   = lt;
        swapped_d = swapped_q | lt;
        if (idx_q == last_idx) begin
          if (!swapped_d || pass_q == LastPass) begin
            state_d  = S_DRAIN;
            rd_idx_d = '0;
          end else begin
            pass_d    = pass_q + IW'(1);
            idx_d     = '0;
            swapped_d = 1'b0;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          rd_idx_d = rd_idx_q + IW'(1);
          if (rd_idx_q == LastCnt) begin
            state_d  = S_LOAD;
            rd_idx_d = '0;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (load_we) begin
        mem[wr_idx_q[AW-1:0]] <= $signed(in_data);
      end else if (swap_en) begin
        mem[idx_hi] <= mem[idx_lo];
        mem[idx_lo] <= mem[idx_hi];
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q == S_SORT) || (state_q == S_DRAIN);
  assign out_data  = out_valid ? mem[rd_idx_q[AW-1:0]] : '0;

endmodule

// File: tb/tb_sort_sequencer.sv
// Randomized self-checking bench for sort_sequencer against a plain sorted-array model.
module tb_sort_sequencer;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  sort_sequencer #(
    .N     (32),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic signed [31:0] stim [D];
  logic signed [31:0] expv [D];
  logic signed [31:0] got  [D];
  int sort_cycles;
  int cycles_to_valid;
  int ready_bad;
  int stall_bad;
  int timeout;
  logic ready_after;
  logic valid_after;

  // Reference: ascending signed order of the loaded words.
  task automatic ref_sort();
    logic signed [31:0] t;
    for (int i = 0; i < D; i++) expv[i] = stim[i];
    for (int i = 1; i < D; i++) begin
      for (int j = i; j > 0 && expv[j] < expv[j-1]; j--) begin
        t = expv[j]; expv[j] = expv[j-1]; expv[j-1] = t;
      end
    end
  endtask

  task automatic rand_stim();
    for (int i = 0; i < D; i++) stim[i] = $signed($urandom());
    stim[$urandom_range(0, D-1)] = stim[$urandom_range(0, D-1)];
  endtask

  // Starts and ends on a negedge; last negedge is the first cycle after the final load.
  task automatic load_batch(input bit gaps);
    int n = 0;
    int cyc = 0;
    bit fire;
    while (n < D && cyc < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = stim[n];
      fire = in_valid && in_ready;
      @(posedge clk);
      if (fire) n++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = $urandom();
    if (n < D) timeout++;
  endtask

  task automatic wait_sort();
    int cyc = 1;
    sort_cycles = 0;
    while (!out_valid && cyc < 200) begin
      if (busy) sort_cycles++;
      if (in_ready) ready_bad++;
      @(negedge clk);
      cyc++;
    end
    cycles_to_valid = cyc;
    if (!out_valid) timeout++;
  endtask

  task automatic drain(input int stall_at, input bit hold_ready);
    int n = 0;
    int cyc = 0;
    int stalled = 0;
    bit prev_stall = 1'b0;
    logic [31:0] held = '0;
    bit fire;
    while (n < D && cyc < 400) begin
      if (n == stall_at && stalled < 3 && !hold_ready) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (prev_stall && out_data !== held) stall_bad++;
      if (out_valid && in_ready) ready_bad++;
      prev_stall = out_valid && !out_ready;
      held = out_data;
      fire = out_valid && out_ready;
      if (fire) got[n] = out_data;
      @(posedge clk);
      if (fire) n++;
      @(negedge clk);
      cyc++;
    end
    ready_after = in_ready;
    valid_after = out_valid;
    if (!hold_ready) out_ready = 1'b0;
    if (n < D) timeout++;
  endtask

  task automatic clear_obs();
    ready_bad = 0;
    stall_bad = 0;
    timeout   = 0;
    for (int i = 0; i < D; i++) got[i] = 'x;
  endtask

  task automatic check_words(input string name);
    for (int i = 0; i < D; i++) begin
      tests++;
      if (got[i] !== expv[i]) begin
        fails++;
        $display("FAIL %s word%0d: got %0d expected %0d", name, i, got[i], expv[i]);
      end
    end
    tests++;
    if (timeout !== 0) begin
      fails++;
      $display("FAIL %s timeout: got %0d bound expiries expected 0", name, timeout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL reset: got rdy/vld/busy=%b data=%h expected 100 data=0",
               {in_ready, out_valid, busy}, out_data);
    end
  endtask

  task automatic test_reverse();
    clear_obs();
    for (int i = 0; i < D; i++) stim[i] = D - 1 - i;
    ref_sort();
    load_batch(1'b0);
    wait_sort();
    drain(-1, 1'b0);
    check_words("reverse");
    tests++;
    if (sort_cycles !== 28) begin
      fails++;
      $display("FAIL reverse_latency: got %0d sort cycles expected 28", sort_cycles);
    end
  endtask

  task automatic test_sign();
    clear_obs();
    stim[0] = -1;           stim[1] = 5;  stim[2] = 32'sh80000000; stim[3] = 32'sh7FFFFFFF;
    stim[4] = 0;            stim[5] = -5; stim[6] = 3;             stim[7] = 3;
    expv[0] = 32'sh80000000; expv[1] = -5; expv[2] = -1; expv[3] = 0;
    expv[4] = 3;            expv[5] = 3;  expv[6] = 5;  expv[7] = 32'sh7FFFFFFF;
    load_batch(1'b0);
    wait_sort();
    drain(-1, 1'b0);
    check_words("sign");
  endtask

  task automatic test_early_exit();
    clear_obs();
    for (int i = 0; i < D; i++) stim[i] = i + 1;
    ref_sort();
    load_batch(1'b0);
    wait_sort();
    drain(-1, 1'b0);
    check_words("early");
    tests++;
    if (sort_cycles !== 7 || cycles_to_valid !== 8) begin
      fails++;
      $display("FAIL early_latency: got sort=%0d valid_at=%0d expected sort=7 valid_at=8",
               sort_cycles, cycles_to_valid);
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    rand_stim();
    ref_sort();
    load_batch(1'b1);
    wait_sort();
    drain(3, 1'b0);
    check_words("backpressure");
    tests++;
    if (stall_bad !== 0 || ready_bad !== 0) begin
      fails++;
      $display("FAIL backpressure_hold: got stall_changes=%0d ready_while_busy=%0d expected 0 0",
               stall_bad, ready_bad);
    end
  endtask

  task automatic test_reset_mid_sort();
    clear_obs();
    rand_stim();
    load_batch(1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL midsort_reset: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    rand_stim();
    ref_sort();
    load_batch(1'b1);
    wait_sort();
    drain(-1, 1'b0);
    check_words("after_reset");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      clear_obs();
      rand_stim();
      ref_sort();
      load_batch(1'b0);
      wait_sort();
      drain(-1, 1'b1);
      check_words("back_to_back");
      tests++;
      if (ready_after !== 1'b1 || valid_after !== 1'b0) begin
        fails++;
        $display("FAIL b2b_reready: got in_ready=%b out_valid=%b expected 1 0",
                 ready_after, valid_after);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_reverse();
    test_sign();
    test_early_exit();
    test_backpressure();
    test_reset_mid_sort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
